// File: rtl/variable_seq_gen.sv
// variable_seq_gen: serial pattern transmitter feeding the variable sequence
// detector. A loaded DATA_SIZE-bit pattern is shifted out LSB first as frames,
// with a programmable repeat count, an idle gap between frames, abort, and a
// start/busy/done handshake. All outputs are registered, and they are computed
// from the next state, so they line up with the state the FSM is in.
//
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// (^pattern) as one extra valid cycle at the end of each frame.
module variable_seq_gen #(
  parameter int DATA_SIZE = 4,
  parameter int CNT_W     = 8,
  parameter int GAP_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] seq_in,
  input  logic                 load,
  input  logic                 start,
  input  logic [CNT_W-1:0]     repeat_cnt,
  input  logic [GAP_W-1:0]     gap_len,
  input  logic                 abort,
  output logic [DATA_SIZE-1:0] reg_loaded,
  output logic                 d_out,
  output logic                 d_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(DATA_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [DATA_SIZE-1:0] tx_pat;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     next_idx;
  logic [CNT_W-1:0]     rep_left;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 frame_end;

`ifdef SEQ_GEN_PARITY_EN
  logic                 par_phase;
`endif

  // bit_idx always names the bit currently on d_out; next_idx is the one after
  assign next_idx = bit_idx + IDX_W'(1);

  // The last valid cycle of a frame: the parity cycle when enabled, else the MSB
`ifdef SEQ_GEN_PARITY_EN
  assign frame_end = par_phase;
`else
  assign frame_end = (bit_idx == LAST_IDX);
`endif

  // Pattern register: load is honoured in every state, reset wins
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_loaded <= '0;
    end else if (load) begin
      reg_loaded <= seq_in;
    end
  end

  // Transmit FSM plus registered outputs; abort beats every frame-end decision
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_pat   <= '0;
      bit_idx  <= '0;
      rep_left <= '0;
      gap_cnt  <= '0;
      d_out    <= 1'b0;
      d_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          d_out   <= 1'b0;
          d_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            // A load in the same cycle as start is used for the first frame
            tx_pat   <= load ? seq_in : reg_loaded;
            d_out    <= load ? seq_in[0] : reg_loaded[0];
            d_valid  <= 1'b1;
            busy     <= 1'b1;
            bit_idx  <= '0;
            rep_left <= repeat_cnt;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            state    <= IDLE;
            bit_idx  <= '0;
            rep_left <= '0;
            gap_cnt  <= '0;
            d_out    <= 1'b0;
            d_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par_phase <= 1'b0;
`endif
          end else if (frame_end) begin
            bit_idx <= '0;
`ifdef SEQ_GEN_PARITY_EN
            par_phase <= 1'b0;
`endif
            if (rep_left == CNT_W'(1)) begin
              // Final frame of a counted run
              state   <= DONE;
              d_out   <= 1'b0;
              d_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              // rep_left of zero means continuous mode and is never decremented
              if (rep_left != '0) begin
                rep_left <= rep_left - CNT_W'(1);
              end
              if (gap_len == '0) begin
                // Back-to-back: next frame picks up the current pattern
                tx_pat <= reg_loaded;
                d_out  <= reg_loaded[0];
              end else begin
                state   <= GAP;
                gap_cnt <= gap_len;
                d_out   <= 1'b0;
                d_valid <= 1'b0;
              end
            end
          end
`ifdef SEQ_GEN_PARITY_EN
          else if (bit_idx == LAST_IDX) begin
            par_phase <= 1'b1;
            d_out     <= ^tx_pat;
          end
`endif
          else begin
            bit_idx <= next_idx;
            d_out   <= tx_pat[next_idx];
          end
        end

        GAP: begin
          if (abort) begin
            state    <= IDLE;
            bit_idx  <= '0;
            rep_left <= '0;
            gap_cnt  <= '0;
            d_out    <= 1'b0;
            d_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            // Gap over: reload so a pattern loaded meanwhile takes effect now
            state   <= SHIFT;
            tx_pat  <= reg_loaded;
            bit_idx <= '0;
            d_out   <= reg_loaded[0];
            d_valid <= 1'b1;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          d_out   <= 1'b0;
          d_valid <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          d_out   <= 1'b0;
          d_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_variable_seq_gen.sv
// tb_variable_seq_gen: directed table vectors, hand-written corner sequences
// and randomized traffic, all checked every cycle against a slot-list model
// of the transmitter (each transmission is planned as a list of bit/gap/done
// slots that are consumed one per clock).
module tb_variable_seq_gen;

  localparam int DS = 4;
  localparam int CW = 8;
  localparam int GW = 4;
  localparam int IW = $clog2(DS);
`ifdef SEQ_GEN_PARITY_EN
  localparam int FL = DS + 1;
`else
  localparam int FL = DS;
`endif

  localparam int S_GAP  = -1;
  localparam int S_DONE = -2;
  localparam int S_NONE = -3;

  logic          clk = 1'b0;
  logic          reset, load, start, abort;
  logic [DS-1:0] seq_in;
  logic [CW-1:0] repeat_cnt;
  logic [GW-1:0] gap_len;
  logic [DS-1:0] reg_loaded;
  logic          d_out, d_valid, busy, done;

  always #5 clk = ~clk;

  variable_seq_gen #(.DATA_SIZE(DS), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .reset(reset), .seq_in(seq_in), .load(load), .start(start),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len), .abort(abort),
    .reg_loaded(reg_loaded), .d_out(d_out), .d_valid(d_valid),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            plan[$];
  int            cur = S_NONE;
  logic [DS-1:0] m_reg = '0;
  logic [DS-1:0] m_pat = '0;
  bit            m_cont = 1'b0;
  int            m_gap = 0;

  // Observed traffic
  bit rxBits[$];
  int doneCount = 0;
  int busyCount = 0;

  typedef struct {
    logic          rst;
    logic          ld;
    logic [DS-1:0] seq;
    logic          st;
    logic [CW-1:0] rep;
    logic [GW-1:0] gap;
    logic          ab;
    logic [DS+3:0] exp;   // {reg_loaded, d_out, d_valid, busy, done}
  } vec_t;

  vec_t vecs[$];

  task automatic addFrame();
    for (int i = 0; i < FL; i++) plan.push_back(i);
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    logic [DS-1:0] oldReg;
    int n;
    oldReg = m_reg;
    if (reset) begin
      plan.delete();
      cur = S_NONE;
      m_reg = '0;
      m_pat = '0;
      m_cont = 1'b0;
      return;
    end
    if (cur >= S_GAP && abort) begin
      plan.delete();
      cur = S_NONE;
    end else if (cur >= S_GAP) begin
      if (plan.size() == 0) begin
        repeat (m_gap) plan.push_back(S_GAP);
        addFrame();
      end
      cur = plan.pop_front();
      if (cur == 0) m_pat = oldReg;
    end else if (cur == S_DONE) begin
      cur = S_NONE;
    end else if (start) begin
      m_pat  = load ? seq_in : oldReg;
      m_gap  = int'(gap_len);
      m_cont = (repeat_cnt == '0);
      n = m_cont ? 1 : int'(repeat_cnt);
      for (int f = 0; f < n; f++) begin
        if (f > 0) repeat (m_gap) plan.push_back(S_GAP);
        addFrame();
      end
      if (!m_cont) plan.push_back(S_DONE);
      cur = plan.pop_front();
    end
    if (load) m_reg = seq_in;
  endtask

  function automatic logic [DS+3:0] modelExp();
    logic dq;
    logic [IW-1:0] ix;
    dq = 1'b0;
    ix = IW'(cur);
    if (cur >= 0 && cur < DS) dq = m_pat[ix];
    else if (cur == DS) dq = ^m_pat;
    return {m_reg, dq, (cur >= 0), (cur >= S_GAP), (cur == S_DONE)};
  endfunction

  task automatic checkOutput(input string name, input logic [DS+3:0] exp);
    logic [DS+3:0] act;
    act = {reg_loaded, d_out, d_valid, busy, done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got reg=%b dout=%b dv=%b busy=%b done=%b, want reg=%b dout=%b dv=%b busy=%b done=%b",
               name, $time, act[DS+3:4], act[3], act[2], act[1], act[0],
               exp[DS+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [DS-1:0] s,
                               input logic st, input logic [CW-1:0] rc,
                               input logic [GW-1:0] gl, input logic ab);
    reset = r; load = ld; seq_in = s; start = st;
    repeat_cnt = rc; gap_len = gl; abort = ab;
    @(posedge clk);
    modelStep();
    #1;
    if (d_valid) rxBits.push_back(d_out);
    if (done) doneCount++;
    if (busy) busyCount++;
    checkOutput("model", modelExp());
  endtask

  task automatic step();
    applyStimulus(1'b0, 1'b0, seq_in, 1'b0, repeat_cnt, gap_len, 1'b0);
  endtask

  task automatic clearStats();
    rxBits.delete();
    doneCount = 0;
    busyCount = 0;
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while ((busy || done || cur != S_NONE) && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (busy || done) begin
      errors++;
      $display("[TB] FAIL waitIdle: busy=%b done=%b after %0d cycles, want idle", busy, done, bound);
    end
  endtask

  function automatic logic [DS-1:0] frameAt(input int base);
    logic [DS-1:0] v;
    v = '0;
    for (int i = 0; i < DS; i++)
      if (base + i < rxBits.size()) v[i] = rxBits[base + i];
    return v;
  endfunction

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; abort = 1'b0;
    seq_in = '0; repeat_cnt = '0; gap_len = '0;

    // ---------------- table-driven vectors ----------------
`ifdef SEQ_GEN_PARITY_EN
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 8'd0, 4'd0, 1'b0, {4'b0000, 4'b0000}});
    vecs.push_back('{1'b0, 1'b1, 4'b0111, 1'b0, 8'd0, 4'd0, 1'b0, {4'b0111, 4'b0000}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 8'd1, 4'd0, 1'b0, {4'b0111, 4'b1110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b0111, 4'b1110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b0111, 4'b1110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b0111, 4'b0110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b0111, 4'b1110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b0111, 4'b0001}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b0111, 4'b0000}});
`else
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 8'd0, 4'd0, 1'b0, {4'b0000, 4'b0000}});
    vecs.push_back('{1'b0, 1'b1, 4'b1011, 1'b0, 8'd0, 4'd0, 1'b0, {4'b1011, 4'b0000}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 8'd1, 4'd0, 1'b0, {4'b1011, 4'b1110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b1011, 4'b1110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b1011, 4'b0110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b1011, 4'b1110}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b1011, 4'b0001}});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0, {4'b1011, 4'b0000}});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].seq, vecs[i].st,
                    vecs[i].rep, vecs[i].gap, vecs[i].ab);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---------------- 0110 x3 with gap 2 ----------------
    clearStats();
    applyStimulus(1'b0, 1'b1, 4'b0110, 1'b0, 8'd3, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 8'd3, 4'd2, 1'b0);
    waitIdle(60);
    checkVal("rep3_busy_cycles", busyCount, 3 * FL + 2 * 2);
    checkVal("rep3_done_count", doneCount, 1);
    checkVal("rep3_bits", rxBits.size(), 3 * FL);
    checkVal("rep3_frame3", int'(frameAt(2 * FL)), 4'b0110);

    // ---------------- same-cycle load beats reg_loaded ----------------
    clearStats();
    applyStimulus(1'b0, 1'b1, 4'b0011, 1'b0, 8'd1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1100, 1'b1, 8'd1, 4'd0, 1'b0);
    waitIdle(30);
    checkVal("same_cycle_load_frame", int'(frameAt(0)), 4'b1100);

    // ---------------- load mid-frame applies at next frame ----------------
    clearStats();
    applyStimulus(1'b0, 1'b1, 4'b0101, 1'b0, 8'd2, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 8'd2, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0, 8'd2, 4'd1, 1'b0);
    waitIdle(40);
    checkVal("midload_frame1", int'(frameAt(0)), 4'b0101);
    checkVal("midload_frame2", int'(frameAt(FL)), 4'b1111);

    // ---------------- continuous mode then abort ----------------
    clearStats();
    applyStimulus(1'b0, 1'b1, 4'b1001, 1'b0, 8'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 8'd0, 4'd0, 1'b0);
    repeat (3 * FL + 1) step();
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 8'd0, 4'd0, 1'b1);
    checkVal("abort_dvalid", int'(d_valid), 0);
    checkVal("abort_busy", int'(busy), 0);
    repeat (4) step();
    checkVal("cont_frame2", int'(frameAt(FL)), 4'b1001);
    checkVal("cont_frame3", int'(frameAt(2 * FL)), 4'b1001);
    checkVal("abort_no_done", doneCount, 0);

    // ---------------- reset on the third bit ----------------
    clearStats();
    applyStimulus(1'b0, 1'b1, 4'b1010, 1'b0, 8'd1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 8'd1, 4'd0, 1'b0);
    step();
    step();
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 8'd1, 4'd0, 1'b0);
    checkOutput("reset_midframe", '0);
    repeat (4) step();
    checkVal("reset_no_done", doneCount, 0);

    // ---------------- start while busy is ignored ----------------
    clearStats();
    applyStimulus(1'b0, 1'b1, 4'b0110, 1'b0, 8'd2, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 8'd2, 4'd0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 8'd5, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 8'd2, 4'd0, 1'b0);
    waitIdle(40);
    checkVal("busy_start_bits", rxBits.size(), 2 * FL);
    checkVal("busy_start_done", doneCount, 1);

    // ---------------- randomized traffic against the model ----------------
    for (int t = 0; t < 40; t++) begin
      logic [DS-1:0] pat;
      logic [CW-1:0] rep;
      logic [GW-1:0] gap;
      int limit;
      pat = DS'($urandom);
      rep = CW'($urandom_range(0, 3));
      gap = GW'($urandom_range(0, 3));
      limit = $urandom_range(2, 25);
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b0, 1'b1, pat, 1'b0, rep, gap, 1'b0);
        applyStimulus(1'b0, 1'b0, DS'($urandom), 1'b1, rep, gap, 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b1, pat, 1'b1, rep, gap, 1'b0);
      end
      for (int c = 0; c < 60; c++) begin
        logic ab, r, ld, st;
        if (cur == S_NONE) break;
        ab = ((rep == '0) && c == limit) || ($urandom_range(0, 39) == 0);
        r  = ($urandom_range(0, 79) == 0);
        ld = ($urandom_range(0, 5) == 0);
        st = ($urandom_range(0, 7) == 0);
        applyStimulus(r, ld, DS'($urandom), st,
                      st ? CW'($urandom_range(0, 3)) : rep, gap, ab);
      end
      waitIdle(20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/variable_seq_gen.md
Name: variable_seq_gen

Overview:
- Serial pattern transmitter that drives the single-bit serial stream consumed by the team's variable sequence detector.
- Holds a loadable DATA_SIZE-bit pattern and shifts it out LSB first, so the detector's right-shifting register aligns bit 0 with reg_loaded[0].
- Supports a programmable repeat count, an idle gap between repeats, abort, and a start/busy/done handshake.
- Used as stimulus source and loopback partner for the detector.

Parameters:
- DATA_SIZE, 4, pattern width in bits (>=2).
- CNT_W, 8, width of repeat counter.
- GAP_W, 4, width of inter-frame gap counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous reset, active-high.
- seq_in  input  DATA_SIZE  pattern to load.
- load  input  1  capture seq_in into reg_loaded.
- start  input  1  begin transmission (accepted only in IDLE).
- repeat_cnt  input  CNT_W  number of frames; 0 = continuous until abort.
- gap_len  input  GAP_W  idle cycles between frames; 0 = back-to-back.
- abort  input  1  terminate transmission.
- reg_loaded  output  DATA_SIZE  currently loaded pattern.
- d_out  output  1  serial data; feeds detector d_in.
- d_valid  output  1  d_out carries a pattern bit this cycle.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: reg_loaded=0, d_out=0, d_valid=0, busy=0, done=0; FSM to IDLE; all counters 0.
- reset dominates every other input. Asserting it mid-frame clears all state at that edge and emits no done.
- All outputs are registered.
- reg_loaded: load=1 captures seq_in; otherwise it holds. load is honoured in every state.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE, start=1:
  - tx_pat <= (load ? seq_in : reg_loaded), so a same-cycle load is used.
  - rep_left <= repeat_cnt; bit_idx <= 0; next state SHIFT.
  - First bit appears on d_out the following cycle (latency 1).
- SHIFT, each cycle:
  - d_out = tx_pat[bit_idx], d_valid=1, bit_idx increments.
  - tx_pat is a shadow copy; load during SHIFT or GAP does not alter the frame in flight.
- End of frame (bit_idx = DATA_SIZE-1):
  - rep_left==1 → DONE.
  - Otherwise decrement rep_left, except when repeat_cnt was 0 (no decrement; continuous mode).
  - Then gap_len==0 → SHIFT with bit_idx=0, no bubble; gap_len>0 → GAP.
- GAP:
  - d_valid=0, d_out=0 for exactly gap_len cycles.
  - gap_len is sampled at frame end.
  - Then SHIFT; tx_pat is reloaded from reg_loaded, so a new pattern takes effect on the next frame boundary.
- DONE: done=1 for one cycle, busy=0, d_valid=0 → IDLE. start in DONE is ignored.
- busy=1 exactly in SHIFT and GAP. start while busy is ignored.
- abort (SHIFT or GAP): next edge → IDLE, d_valid=0, busy=0, done not pulsed. abort beats frame-end transitions in the same cycle.
- d_out=0 whenever d_valid=0.
- Counter widths:
  - bit_idx: $clog2(DATA_SIZE) bits, wraps to 0 at each frame.
  - gap counter: GAP_W bits.
  - rep_left: CNT_W bits, never underflows.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined:
  - After bit DATA_SIZE-1 of each frame, one extra SHIFT cycle drives the even-parity bit (^tx_pat) with d_valid=1.
  - Frame length is DATA_SIZE+1. Gap, repeat and done timing count from the parity bit.
- Undefined: no parity cycle; frame length is exactly DATA_SIZE.

Test Plan:
- DATA_SIZE=4, reset, load seq_in=4'b1011, then start with repeat_cnt=1, gap_len=0 → d_out=1,1,0,1 with d_valid=1 on cycles 1–4 after start; done pulses at cycle 5; busy=1 on cycles 1–4.
- Pattern 4'b0110, repeat_cnt=3, gap_len=2 → 0,1,1,0, then 2 cycles d_valid=0, repeated 3 times; done once; 16 busy cycles total. Loopback to the detector with reg_loaded=4'b0110 → seq_detected asserts after each frame.
- repeat_cnt=0, gap_len=0, pattern 4'b1001 → continuous 1,0,0,1,…; abort mid-frame → next cycle d_valid=0, busy=0, done never pulses.
- Same-cycle load=1, seq_in=4'b1100, start=1 with reg_loaded=4'b0011 → transmits 0,0,1,1. A load of 4'b1111 during frame 1 of 2 (gap_len=1) → frame 1 unchanged, frame 2 = 1,1,1,1.
- reset asserted on the third bit of a frame → all outputs 0 next cycle, no done, reg_loaded=0. start during busy → ignored, frame count unchanged.
- SEQ_GEN_PARITY_EN defined, pattern 4'b0111, repeat_cnt=1 → d_out=1,1,1,0,1 (parity 1); done at cycle 6.
